// File: rtl/mbx_pkg.sv
// Mailbox control package.
// Purpose: state encoding shared by the per-channel mailbox FSM and the
//          multi-channel wrapper, plus a small decode helper.
// Contents: mbx_ctrl_state_e (3-bit), mbx_accepts_write().
package mbx_pkg;

  typedef enum logic [2:0] {
    MbxIdle          = 3'b000,
    MbxWrite         = 3'b001,
    MbxWaitFinalWord = 3'b010,
    MbxRead          = 3'b011,
    MbxError         = 3'b100,
    MbxSysAbortHost  = 3'b101
  } mbx_ctrl_state_e;

  // States in which a writer word is counted into the mailbox occupancy.
  function automatic logic mbx_accepts_write(input mbx_ctrl_state_e s);
    return (s == MbxIdle) || (s == MbxWrite) || (s == MbxWaitFinalWord);
  endfunction

endpackage

// File: rtl/mbx_chan_fsm.sv
// Single mailbox channel controller.
// Purpose: control FSM for one inbound or outbound mailbox channel, with a
//          saturating occupancy counter (overflow -> Error) and an
//          abort-acknowledge timeout down-counter.
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   mbx_range_valid_i ... reader_read_valid_i   per-channel requests/events
//   mbx_empty_o/write_o/read_o/sys_abort_o      state decodes
//   mbx_ready_update_o, mbx_ready_o             outbound Ready strobe/value
//   mbx_irq_ready_o, mbx_irq_abort_o            state entry events
//   mbx_overflow_o, mbx_abort_timeout_o         1-cycle event pulses
//   mbx_state_error_o                           illegal state encoding
//   mbx_word_cnt_o                              registered occupancy
//
// state            | meaning
// -----------------+------------------------------------------------------
// MbxIdle          | no transfer; outbound waits for close, inbound for a write
// MbxWrite         | inbound data being written
// MbxWaitFinalWord | closed, waiting for the last SRAM write to commit
// MbxRead          | data available to the reader
// MbxError         | host error or occupancy overflow; waits for system abort
// MbxSysAbortHost  | system abort pending; only the host ack releases it
module mbx_chan_fsm
  import mbx_pkg::*;
#(
  parameter bit          CfgOmbx      = 1'b0,
  parameter int unsigned DepthWords   = 1024,
  parameter int unsigned AbortTimeout = 256,
  localparam int unsigned CntW        = $clog2(DepthWords + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mbx_range_valid_i,
  input  logic            hostif_abort_ack_i,
  input  logic            mbx_error_set_i,
  input  logic            sysif_control_abort_set_i,
  input  logic            sys_read_all_i,
  input  logic            writer_close_mbx_i,
  input  logic            writer_last_word_written_i,
  input  logic            writer_write_valid_i,
  input  logic            reader_read_valid_i,
  output logic            mbx_empty_o,
  output logic            mbx_write_o,
  output logic            mbx_read_o,
  output logic            mbx_sys_abort_o,
  output logic            mbx_ready_update_o,
  output logic            mbx_ready_o,
  output logic            mbx_irq_ready_o,
  output logic            mbx_irq_abort_o,
  output logic            mbx_overflow_o,
  output logic            mbx_abort_timeout_o,
  output logic            mbx_state_error_o,
  output logic [CntW-1:0] mbx_word_cnt_o
);

  localparam logic [CntW-1:0] CntMax  = CntW'(DepthWords);
  localparam int unsigned     TmrW    = (AbortTimeout > 1) ? $clog2(AbortTimeout) : 1;
  localparam logic [TmrW-1:0] TmrLoad = (AbortTimeout > 0) ? TmrW'(AbortTimeout - 1) : '0;
  localparam bit              TmrEn   = (AbortTimeout != 0);

  mbx_ctrl_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            tmr_done_q, tmr_done_d;

  logic cnt_inc, cnt_dec, cnt_full, overflow, legal;
  logic ready_set, ready_clr;

  always_comb begin
    state_d             = state_q;
    legal               = 1'b1;
    cnt_d               = cnt_q;
    tmr_d               = TmrLoad;
    tmr_done_d          = 1'b0;
    mbx_abort_timeout_o = 1'b0;

    cnt_inc  = writer_write_valid_i & mbx_accepts_write(state_q);
    cnt_dec  = reader_read_valid_i & (state_q == MbxRead);
    cnt_full = (cnt_q == CntMax);
    overflow = cnt_inc & cnt_full;

    case (state_q)
      MbxIdle: begin
        if (mbx_range_valid_i) begin
          if (CfgOmbx && writer_close_mbx_i)           state_d = MbxRead;
          else if (!CfgOmbx && writer_write_valid_i)   state_d = MbxWrite;
        end
      end
      MbxWrite: begin
        if (writer_close_mbx_i) begin
          state_d = writer_last_word_written_i ? MbxRead : MbxWaitFinalWord;
        end
      end
      MbxWaitFinalWord: if (writer_last_word_written_i) state_d = MbxRead;
      MbxRead:          if (sys_read_all_i)             state_d = MbxIdle;
      MbxError:         state_d = MbxError;
      MbxSysAbortHost:  state_d = MbxSysAbortHost;
      default: begin
        state_d = MbxIdle;
        legal   = 1'b0;
      end
    endcase

    // Priority overrides; SysAbortHost is sticky until the host acknowledges.
    if (legal) begin
      if (state_q == MbxSysAbortHost) begin
        if (hostif_abort_ack_i) state_d = MbxIdle;
      end else if (hostif_abort_ack_i) begin
        state_d = MbxIdle;
      end else if (mbx_error_set_i || overflow) begin
        state_d = MbxError;
      end else if (sysif_control_abort_set_i) begin
        state_d = MbxSysAbortHost;
      end
    end

    // Occupancy: cleared on entry to Idle, otherwise saturating up/down.
    if ((state_d == MbxIdle) && (state_q != MbxIdle)) begin
      cnt_d = '0;
    end else if (cnt_inc && !cnt_dec && !cnt_full) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (cnt_dec && !cnt_inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end

    // Timeout timer counts down only while staying in SysAbortHost; the done
    // flag keeps the terminal count from firing again before exit.
    if ((state_q == MbxSysAbortHost) && (state_d == MbxSysAbortHost)) begin
      tmr_d      = (tmr_q == '0) ? tmr_q : tmr_q - TmrW'(1);
      tmr_done_d = tmr_done_q;
      if (TmrEn && (tmr_q == '0) && !tmr_done_q) begin
        mbx_abort_timeout_o = 1'b1;
        tmr_done_d          = 1'b1;
      end
    end
  end

  always_comb begin
    ready_set = (state_q == MbxIdle) & mbx_range_valid_i & writer_close_mbx_i;
    ready_clr = mbx_error_set_i | sysif_control_abort_set_i | hostif_abort_ack_i |
                ((state_q == MbxRead) & sys_read_all_i);
    if (CfgOmbx) begin
      mbx_ready_update_o = ready_set | ready_clr;
      mbx_ready_o        = ~ready_clr;
    end else begin
      mbx_ready_update_o = 1'b0;
      mbx_ready_o        = 1'b1;
    end
  end

  assign mbx_empty_o       = (state_q == MbxIdle) & mbx_range_valid_i;
  assign mbx_write_o       = (state_q == MbxWrite);
  assign mbx_read_o        = (state_q == MbxRead);
  assign mbx_sys_abort_o   = (state_q == MbxSysAbortHost);
  assign mbx_irq_ready_o   = (state_d == MbxRead) & (state_q != MbxRead);
  assign mbx_irq_abort_o   = (state_d == MbxSysAbortHost) & (state_q != MbxSysAbortHost);
  assign mbx_overflow_o    = overflow;
  assign mbx_state_error_o = ~legal;
  assign mbx_word_cnt_o    = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= MbxIdle;
      cnt_q      <= '0;
      tmr_q      <= TmrLoad;
      tmr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      tmr_done_q <= tmr_done_d;
    end
  end

endmodule

// File: rtl/mbx_fsm_multi.sv
// N-channel mailbox control.
// Purpose: one independent mbx_chan_fsm per channel; OmbxMask bit c selects
//          outbound (1) or inbound (0) behaviour for channel c.
// Ports: all request/event inputs and status/event outputs are NumChan-wide
//        vectors, bit c belonging to channel c. mbx_word_cnt_o packs the
//        per-channel CntW-bit occupancy counts, channel c at [c*CntW +: CntW].
module mbx_fsm_multi
  import mbx_pkg::*;
#(
  parameter int unsigned        NumChan      = 4,
  parameter logic [NumChan-1:0] OmbxMask     = 4'hA,
  parameter int unsigned        DepthWords   = 1024,
  parameter int unsigned        AbortTimeout = 256,
  localparam int unsigned       CntW         = $clog2(DepthWords + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumChan-1:0]      mbx_range_valid_i,
  input  logic [NumChan-1:0]      hostif_abort_ack_i,
  input  logic [NumChan-1:0]      mbx_error_set_i,
  input  logic [NumChan-1:0]      sysif_control_abort_set_i,
  input  logic [NumChan-1:0]      sys_read_all_i,
  input  logic [NumChan-1:0]      writer_close_mbx_i,
  input  logic [NumChan-1:0]      writer_last_word_written_i,
  input  logic [NumChan-1:0]      writer_write_valid_i,
  input  logic [NumChan-1:0]      reader_read_valid_i,
  output logic [NumChan-1:0]      mbx_empty_o,
  output logic [NumChan-1:0]      mbx_write_o,
  output logic [NumChan-1:0]      mbx_read_o,
  output logic [NumChan-1:0]      mbx_sys_abort_o,
  output logic [NumChan-1:0]      mbx_ready_update_o,
  output logic [NumChan-1:0]      mbx_ready_o,
  output logic [NumChan-1:0]      mbx_irq_ready_o,
  output logic [NumChan-1:0]      mbx_irq_abort_o,
  output logic [NumChan-1:0]      mbx_overflow_o,
  output logic [NumChan-1:0]      mbx_abort_timeout_o,
  output logic [NumChan-1:0]      mbx_state_error_o,
  output logic [NumChan*CntW-1:0] mbx_word_cnt_o
);

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    mbx_chan_fsm #(
      .CfgOmbx      (OmbxMask[c]),
      .DepthWords   (DepthWords),
      .AbortTimeout (AbortTimeout)
    ) u_chan (
      .clk_i                      (clk_i),
      .rst_ni                     (rst_ni),
      .mbx_range_valid_i          (mbx_range_valid_i[c]),
      .hostif_abort_ack_i         (hostif_abort_ack_i[c]),
      .mbx_error_set_i            (mbx_error_set_i[c]),
      .sysif_control_abort_set_i  (sysif_control_abort_set_i[c]),
      .sys_read_all_i             (sys_read_all_i[c]),
      .writer_close_mbx_i         (writer_close_mbx_i[c]),
      .writer_last_word_written_i (writer_last_word_written_i[c]),
      .writer_write_valid_i       (writer_write_valid_i[c]),
      .reader_read_valid_i        (reader_read_valid_i[c]),
      .mbx_empty_o                (mbx_empty_o[c]),
      .mbx_write_o                (mbx_write_o[c]),
      .mbx_read_o                 (mbx_read_o[c]),
      .mbx_sys_abort_o            (mbx_sys_abort_o[c]),
      .mbx_ready_update_o         (mbx_ready_update_o[c]),
      .mbx_ready_o                (mbx_ready_o[c]),
      .mbx_irq_ready_o            (mbx_irq_ready_o[c]),
      .mbx_irq_abort_o            (mbx_irq_abort_o[c]),
      .mbx_overflow_o             (mbx_overflow_o[c]),
      .mbx_abort_timeout_o        (mbx_abort_timeout_o[c]),
      .mbx_state_error_o          (mbx_state_error_o[c]),
      .mbx_word_cnt_o             (mbx_word_cnt_o[c*CntW +: CntW])
    );
  end

endmodule

// File: tb/tb_mbx_fsm_multi.sv
// Bench for mbx_fsm_multi: two instances on shared stimulus (depth 4 and
// depth 16, abort timeout 8), a per-channel reference model checked every
// cycle, plus literal expectations at key points of each directed scenario.
module tb_mbx_fsm_multi;

  localparam int NCH   = 4;
  localparam int DEP_A = 4;
  localparam int DEP_B = 16;
  localparam int TMO   = 8;
  localparam int CW_A  = $clog2(DEP_A + 1);
  localparam int CW_B  = $clog2(DEP_B + 1);
  localparam logic [3:0] OUTB = 4'hA;

  localparam int S_IDLE = 0, S_WR = 1, S_WFW = 2, S_RD = 3, S_ERR = 4, S_SAH = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] in_rv, in_ack, in_es, in_ab, in_ra, in_cl, in_lw, in_wv, in_rdv;

  logic [1:0][3:0] o_empty, o_write, o_read, o_sabort, o_rupd, o_rdy;
  logic [1:0][3:0] o_irqr, o_irqa, o_ovf, o_tmo, o_serr;
  logic [NCH*CW_A-1:0] o_cnt_a;
  logic [NCH*CW_B-1:0] o_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  mbx_fsm_multi #(.NumChan(NCH), .OmbxMask(OUTB), .DepthWords(DEP_A), .AbortTimeout(TMO)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .mbx_range_valid_i(in_rv), .hostif_abort_ack_i(in_ack), .mbx_error_set_i(in_es),
    .sysif_control_abort_set_i(in_ab), .sys_read_all_i(in_ra), .writer_close_mbx_i(in_cl),
    .writer_last_word_written_i(in_lw), .writer_write_valid_i(in_wv), .reader_read_valid_i(in_rdv),
    .mbx_empty_o(o_empty[0]), .mbx_write_o(o_write[0]), .mbx_read_o(o_read[0]),
    .mbx_sys_abort_o(o_sabort[0]), .mbx_ready_update_o(o_rupd[0]), .mbx_ready_o(o_rdy[0]),
    .mbx_irq_ready_o(o_irqr[0]), .mbx_irq_abort_o(o_irqa[0]), .mbx_overflow_o(o_ovf[0]),
    .mbx_abort_timeout_o(o_tmo[0]), .mbx_state_error_o(o_serr[0]), .mbx_word_cnt_o(o_cnt_a)
  );

  mbx_fsm_multi #(.NumChan(NCH), .OmbxMask(OUTB), .DepthWords(DEP_B), .AbortTimeout(TMO)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .mbx_range_valid_i(in_rv), .hostif_abort_ack_i(in_ack), .mbx_error_set_i(in_es),
    .sysif_control_abort_set_i(in_ab), .sys_read_all_i(in_ra), .writer_close_mbx_i(in_cl),
    .writer_last_word_written_i(in_lw), .writer_write_valid_i(in_wv), .reader_read_valid_i(in_rdv),
    .mbx_empty_o(o_empty[1]), .mbx_write_o(o_write[1]), .mbx_read_o(o_read[1]),
    .mbx_sys_abort_o(o_sabort[1]), .mbx_ready_update_o(o_rupd[1]), .mbx_ready_o(o_rdy[1]),
    .mbx_irq_ready_o(o_irqr[1]), .mbx_irq_abort_o(o_irqa[1]), .mbx_overflow_o(o_ovf[1]),
    .mbx_abort_timeout_o(o_tmo[1]), .mbx_state_error_o(o_serr[1]), .mbx_word_cnt_o(o_cnt_b)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int dep(input int i);
    return (i == 0) ? DEP_A : DEP_B;
  endfunction

  function automatic int act_cnt(input int i, input int c);
    if (i == 0) return int'(o_cnt_a[c*CW_A +: CW_A]);
    return int'(o_cnt_b[c*CW_B +: CW_B]);
  endfunction

  // ---------------- reference model ----------------
  int m_st[2][NCH], m_cnt[2][NCH], m_ab[2][NCH];   // m_ab: cycles already spent in abort
  int nx_st[2][NCH], nx_cnt[2][NCH], nx_ab[2][NCH];
  bit nx_ok = 1'b0;
  logic [3:0] e_empty, e_write, e_read, e_sabort, e_rupd, e_rdy, e_irqr, e_irqa, e_ovf, e_tmo;

  always @(negedge clk) begin
    if (!rst_n) begin
      nx_ok = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < NCH; c++) begin
          int st, nxt;
          bit wr_acc, rd_acc, ovf, clr, setr;
          st     = m_st[i][c];
          wr_acc = in_wv[c] && (st == S_IDLE || st == S_WR || st == S_WFW);
          rd_acc = in_rdv[c] && (st == S_RD);
          ovf    = wr_acc && (m_cnt[i][c] == dep(i));
          if (st == S_SAH)              nxt = in_ack[c] ? S_IDLE : S_SAH;
          else if (in_ack[c])           nxt = S_IDLE;
          else if (in_es[c] || ovf)     nxt = S_ERR;
          else if (in_ab[c])            nxt = S_SAH;
          else if (st == S_IDLE && in_rv[c] && OUTB[c] && in_cl[c])  nxt = S_RD;
          else if (st == S_IDLE && in_rv[c] && !OUTB[c] && in_wv[c]) nxt = S_WR;
          else if (st == S_WR && in_cl[c])  nxt = in_lw[c] ? S_RD : S_WFW;
          else if (st == S_WFW && in_lw[c]) nxt = S_RD;
          else if (st == S_RD && in_ra[c])  nxt = S_IDLE;
          else                              nxt = st;

          clr  = in_es[c] || in_ab[c] || in_ack[c] || (st == S_RD && in_ra[c]);
          setr = (st == S_IDLE) && in_rv[c] && in_cl[c];
          e_rupd[c]   = OUTB[c] ? (setr || clr) : 1'b0;
          e_rdy[c]    = OUTB[c] ? !clr : 1'b1;
          e_empty[c]  = (st == S_IDLE) && in_rv[c];
          e_write[c]  = (st == S_WR);
          e_read[c]   = (st == S_RD);
          e_sabort[c] = (st == S_SAH);
          e_irqr[c]   = (nxt == S_RD) && (st != S_RD);
          e_irqa[c]   = (nxt == S_SAH) && (st != S_SAH);
          e_ovf[c]    = ovf;
          e_tmo[c]    = (st == S_SAH) && (nxt == S_SAH) && (m_ab[i][c] == TMO - 1);

          if (nxt == S_IDLE && st != S_IDLE)          nx_cnt[i][c] = 0;
          else if (wr_acc && !rd_acc)                 nx_cnt[i][c] = (m_cnt[i][c] < dep(i)) ? m_cnt[i][c] + 1 : dep(i);
          else if (rd_acc && !wr_acc)                 nx_cnt[i][c] = (m_cnt[i][c] > 0) ? m_cnt[i][c] - 1 : 0;
          else                                        nx_cnt[i][c] = m_cnt[i][c];
          nx_ab[i][c] = (st == S_SAH && nxt == S_SAH) ? m_ab[i][c] + 1 : 0;
          nx_st[i][c] = nxt;
          chk($sformatf("word_cnt i%0d c%0d", i, c), act_cnt(i, c), m_cnt[i][c]);
        end
        chk($sformatf("empty i%0d", i),       o_empty[i],  e_empty);
        chk($sformatf("write i%0d", i),       o_write[i],  e_write);
        chk($sformatf("read i%0d", i),        o_read[i],   e_read);
        chk($sformatf("sys_abort i%0d", i),   o_sabort[i], e_sabort);
        chk($sformatf("ready_upd i%0d", i),   o_rupd[i],   e_rupd);
        chk($sformatf("ready i%0d", i),       o_rdy[i],    e_rdy);
        chk($sformatf("irq_ready i%0d", i),   o_irqr[i],   e_irqr);
        chk($sformatf("irq_abort i%0d", i),   o_irqa[i],   e_irqa);
        chk($sformatf("overflow i%0d", i),    o_ovf[i],    e_ovf);
        chk($sformatf("abort_tmo i%0d", i),   o_tmo[i],    e_tmo);
        chk($sformatf("state_err i%0d", i),   o_serr[i],   4'h0);
      end
      nx_ok = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!rst_n) begin
          m_st[i][c]  <= S_IDLE;
          m_cnt[i][c] <= 0;
          m_ab[i][c]  <= 0;
        end else if (nx_ok) begin
          m_st[i][c]  <= nx_st[i][c];
          m_cnt[i][c] <= nx_cnt[i][c];
          m_ab[i][c]  <= nx_ab[i][c];
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {in_rv, in_ack, in_es, in_ab, in_ra, in_cl, in_lw, in_wv, in_rdv} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", o_rdy[0], 4'hF);
    chk("rst rupd", o_rupd[0], 4'h0);
    chk("rst cnt_a", o_cnt_a, 0);
    chk("rst read_b", o_read[1], 4'h0);
    #2 rst_n = 1'b1;
    tick();
    in_rv = 4'hF;
    @(negedge clk) chk("empty all", o_empty[0], 4'hF);

    // 1: outbound ch1, 3 words then close, read back
    tick();
    in_wv = 4'b0010;
    repeat (3) tick();
    in_wv = 4'b0000; in_cl = 4'b0010;
    @(negedge clk);
    chk("t1 irq_ready", o_irqr[0][1], 1);
    chk("t1 ready_upd", o_rupd[0][1], 1);
    chk("t1 ready", o_rdy[0][1], 1);
    chk("t1 cnt3", act_cnt(0, 1), 3);
    tick();
    in_cl = 4'b0000; in_rdv = 4'b0010;
    @(negedge clk);
    chk("t1 read", o_read[0][1], 1);
    chk("t1 irq once", o_irqr[0][1], 0);
    repeat (3) tick();
    in_rdv = 4'b0000; in_ra = 4'b0010;
    @(negedge clk);
    chk("t1 cnt0", act_cnt(0, 1), 0);
    chk("t1 clr upd", o_rupd[0][1], 1);
    chk("t1 clr ready", o_rdy[0][1], 0);
    tick();
    in_ra = 4'b0000;
    @(negedge clk) chk("t1 idle", o_empty[0][1], 1);

    // 2: inbound ch0 via WaitFinalWord
    tick();
    in_wv = 4'b0001;
    tick();
    in_wv = 4'b0000; in_cl = 4'b0001;
    @(negedge clk);
    chk("t2 write", o_write[0][0], 1);
    chk("t2 cnt1", act_cnt(0, 0), 1);
    tick();
    in_cl = 4'b0000; in_lw = 4'b0001;
    @(negedge clk);
    chk("t2 wfw", o_write[0][0], 0);
    chk("t2 irq_ready", o_irqr[0][0], 1);
    tick();
    in_lw = 4'b0000; in_ra = 4'b0001;
    @(negedge clk) chk("t2 read", o_read[0][0], 1);
    tick();
    in_ra = 4'b0000;
    @(negedge clk) chk("t2 cnt0", act_cnt(0, 0), 0);

    // 3: overflow on ch0 (depth 4 instance), then abort
    tick();
    in_wv = 4'b0001;
    repeat (4) tick();
    @(negedge clk);
    chk("t3 ovf a", o_ovf[0][0], 1);
    chk("t3 ovf b", o_ovf[1][0], 0);
    tick();
    in_wv = 4'b0000; in_ab = 4'b0001;
    @(negedge clk);
    chk("t3 cnt hold", act_cnt(0, 0), 4);
    chk("t3 cnt b", act_cnt(1, 0), 5);
    chk("t3 irq_abort a", o_irqa[0][0], 1);
    chk("t3 irq_abort b", o_irqa[1][0], 1);
    tick();
    in_ab = 4'b0000;

    // 4: abort timeout pulses in the 8th cycle of SysAbortHost only
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("t4 tmo k%0d", k), o_tmo[0][0], (k == TMO - 1) ? 1 : 0);
      tick();
    end
    in_ack = 4'b0001;
    @(negedge clk) chk("t4 sabort", o_sabort[0][0], 1);
    tick();
    in_ack = 4'b0000;
    repeat (10) tick();
    @(negedge clk);
    chk("t4 idle", o_empty[0][0], 1);
    chk("t4 cnt b", act_cnt(1, 0), 0);

    // ack in the expiry cycle wins, no pulse (ch2)
    tick();
    in_ab = 4'b0100;
    tick();
    in_ab = 4'b0000;
    repeat (TMO - 1) tick();
    in_ack = 4'b0100;
    @(negedge clk) chk("t4 ack wins", o_tmo[0][2], 0);
    tick();
    in_ack = 4'b0000;
    repeat (3) tick();

    // 5: ch3 in Read; triple request on ch1 (outbound) and ch2 (inbound)
    in_cl = 4'b1000;
    tick();
    in_cl = 4'b0000;
    in_es = 4'b0110; in_ab = 4'b0110; in_ack = 4'b0110;
    @(negedge clk);
    chk("t5 upd ch1", o_rupd[0][1], 1);
    chk("t5 rdy ch1", o_rdy[0][1], 0);
    chk("t5 tie ch2", {o_rupd[0][2], o_rdy[0][2]}, 2'b01);
    chk("t5 ch3 upd", o_rupd[0][3], 0);
    chk("t5 ch3 read", o_read[0][3], 1);
    tick();
    {in_es, in_ab, in_ack} = '0;
    @(negedge clk);
    chk("t5 idle", o_empty[0][2:1], 2'b11);
    chk("t5 ch3 still", o_read[0][3], 1);
    tick();
    in_ra = 4'b1000;
    tick();
    in_ra = 4'b0000;

    // 6: all channels to Read with 7 words (depth 16), then async reset
    in_wv = 4'hF;
    repeat (7) tick();
    in_wv = 4'h0; in_cl = 4'hF; in_lw = 4'hF;
    tick();
    in_cl = 4'h0; in_lw = 4'h0; in_rv = 4'h0;
    @(negedge clk);
    chk("t6 read b", o_read[1], 4'hF);
    for (int c = 0; c < NCH; c++) chk($sformatf("t6 cnt7 c%0d", c), act_cnt(1, c), 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 rst read", o_read[1], 4'h0);
    chk("t6 rst cnt b", o_cnt_b, 0);
    chk("t6 rst cnt a", o_cnt_a, 0);
    chk("t6 rst ready", o_rdy[1], 4'hF);
    chk("t6 rst irq", {o_irqr[1], o_irqa[1], o_ovf[0]}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    in_rv = 4'hF;
    repeat (5) tick();
    @(negedge clk);
    chk("t6 post irq", {o_irqr[0], o_irqr[1], o_irqa[0], o_irqa[1]}, 0);
    chk("t6 post empty", o_empty[1], 4'hF);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
